vga_scanout: RTL and testbench

Reads the 640x480 8-bit intensity framebuffer written by the Julia-set fractal calculator and drives the VGA port. It generates 640x480@60 Hz timing from the 50 MHz system clock using a divide-by-2 pixel enable. It issues one framebuffer read per active pixel and maps intensity to 12-bit RGB. Sync, blanking and colour stay pixel-aligned through the memory-read latency.

---
 rtl/vga_scanout.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Scans the 8-bit intensity framebuffer produced by the Julia-set engine out
// to a VGA port. A divide-by-2 pixel enable derived from the 50 MHz system
// clock paces 640x480@60 Hz raster counters. One framebuffer read is issued
// per visible pixel. The returned intensity is clamped, mapped to 12-bit RGB,
// and emitted together with a one-pixel-delayed copy of sync and blanking, so
// that colour, hsync, vsync and blank_n all describe the same pixel.
//
// Ports
//   clk          in   50 MHz system clock
//   reset        in   asynchronous, active-high
//   calculating  in   fractal engine busy; sampled once per frame
//   fb_addr      out  framebuffer read address (y*H_ACTIVE + x)
//   fb_rd_en     out  read strobe; fb_data is valid on the following clk
//   fb_data      in   intensity word returned by the framebuffer
//   vga_r/g/b    out  4-bit colour channels
//   hsync/vsync  out  active-low sync
//   blank_n      out  high while a visible pixel is being shown
//   frame_start  out  one-clk pulse at the first pixel of each frame
//   draw_x/y     out  raster counter position, undelayed
// ---------------------------------------------------------------------------
module vga_scanout #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int MAX_INTENSITY = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        calculating,
  output logic [18:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [7:0]  fb_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start,
  output logic [9:0]  draw_x,
  output logic [9:0]  draw_y
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_W   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_W   = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST_W  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_W  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_BEG_W  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_W  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG_W  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_W  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0] MAX_INT_W = 8'(MAX_INTENSITY);

  // Clamp, scale to 0..15 via (i*157)>>10, and spread over a red-to-blue ramp.
  // Zero intensity, a held frame or a non-visible pixel all give black.
  function automatic logic [11:0] colour_map(input logic [7:0] data, input logic show);
    logic [7:0]  clamped;
    logic [16:0] product;
    logic [3:0]  level;
    if (data > MAX_INT_W) begin
      clamped = MAX_INT_W;
    end else begin
      clamped = data;
    end
    product = 17'(clamped) * 17'd157;
    level   = 4'(product >> 10);
    if (!show || (clamped == 8'd0)) begin
      return 12'h000;
    end else begin
      return {level, {1'b0, level[3:1]}, 4'd15 - level};
    end
  endfunction

  // State and pipeline registers
  logic        pix_en_r;
  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic [18:0] lin_addr_r;   // address of the next visible pixel to read
  logic        hold_r;
  logic        act_p1_r;     // timing of the pixel whose read is in flight
  logic        hs_p1_r;
  logic        vs_p1_r;
  logic [18:0] fb_addr_r;
  logic        fb_rd_en_r;
  logic        frame_start_r;
  logic [11:0] rgb_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        blank_n_r;

  // Combinational decode
  logic        active_s;
  logic        hs_s;
  logic        vs_s;
  logic        frame_origin_s;
  logic [9:0]  h_next_s;
  logic [9:0]  v_next_s;
  logic [18:0] rd_addr_s;
  logic [18:0] addr_next_s;

  // Raster decode of the current counter position
  always_comb begin
    active_s       = (h_cnt_r < H_ACT_W) && (v_cnt_r < V_ACT_W);
    hs_s           = !((h_cnt_r >= HS_BEG_W) && (h_cnt_r < HS_END_W));
    vs_s           = !((v_cnt_r >= VS_BEG_W) && (v_cnt_r < VS_END_W));
    frame_origin_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
  end

  // Next raster position: h wraps at end of line and carries into v
  always_comb begin
    h_next_s = h_cnt_r;
    v_next_s = v_cnt_r;
    if (h_cnt_r == H_LAST_W) begin
      h_next_s = 10'd0;
      if (v_cnt_r == V_LAST_W) begin
        v_next_s = 10'd0;
      end else begin
        v_next_s = v_cnt_r + 10'd1;
      end
    end else begin
      h_next_s = h_cnt_r + 10'd1;
      v_next_s = v_cnt_r;
    end
  end

  // Linear read address: restart at the frame origin, otherwise walk forward
  always_comb begin
    if (frame_origin_s) begin
      rd_addr_s   = 19'd0;
      addr_next_s = 19'd1;
    end else begin
      rd_addr_s   = lin_addr_r;
      addr_next_s = lin_addr_r + 19'd1;
    end
  end

  // Divide-by-2 pixel enable phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_en_r <= 1'b0;
    end else begin
      pix_en_r <= ~pix_en_r;
    end
  end

  // Raster counters, address accumulator and per-frame hold, stepped once per pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r    <= 10'd0;
      v_cnt_r    <= 10'd0;
      lin_addr_r <= 19'd0;
      hold_r     <= 1'b0;
    end else if (pix_en_r) begin
      h_cnt_r <= h_next_s;
      v_cnt_r <= v_next_s;
      if (active_s) begin
        lin_addr_r <= addr_next_s;
      end
      if (frame_origin_s) begin
        hold_r <= calculating;
      end
    end
  end

  // Read issue and timing capture. These load on the edge that opens the
  // pix_en clk, so strobes are high exactly during that clk and fb_data
  // returns in the clk after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_addr_r     <= 19'd0;
      fb_rd_en_r    <= 1'b0;
      frame_start_r <= 1'b0;
      act_p1_r      <= 1'b0;
      hs_p1_r       <= 1'b1;
      vs_p1_r       <= 1'b1;
    end else if (!pix_en_r) begin
      fb_rd_en_r    <= active_s;
      frame_start_r <= frame_origin_s;
      act_p1_r      <= active_s;
      hs_p1_r       <= hs_s;
      vs_p1_r       <= vs_s;
      if (active_s) begin
        fb_addr_r <= rd_addr_s;
      end
    end else begin
      fb_rd_en_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  // Output stage: colour from the returned word, sync/blank from the captured
  // timing of the same pixel, all presented for the next two clks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r     <= 12'h000;
      hsync_r   <= 1'b1;
      vsync_r   <= 1'b1;
      blank_n_r <= 1'b0;
    end else if (!pix_en_r) begin
      rgb_r     <= colour_map(fb_data, act_p1_r && !hold_r);
      hsync_r   <= hs_p1_r;
      vsync_r   <= vs_p1_r;
      blank_n_r <= act_p1_r;
    end
  end

  assign fb_addr     = fb_addr_r;
  assign fb_rd_en    = fb_rd_en_r;
  assign frame_start = frame_start_r;
  assign vga_r       = rgb_r[11:8];
  assign vga_g       = rgb_r[7:4];
  assign vga_b       = rgb_r[3:0];
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign blank_n     = blank_n_r;
  assign draw_x      = h_cnt_r;
  assign draw_y      = v_cnt_r;

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//
// Self-checking bench for vga_scanout on a reduced raster (same porch
// structure, smaller numbers) so whole frames fit in a short run. Expected
// outputs come from a time-indexed model: pixel index = clks since reset / 2.
// A 1-clk memory responder returns data for each read; the expected colour
// for that pixel is queued when the data is returned and popped when the
// output stage should show it.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int HA = 16, HF = 4, HS = 8, HB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int READS = HA * VA;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
  } out_t;

  localparam out_t RESET_OUT = {12'h000, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic        calculating;
  logic [18:0] fb_addr;
  logic        fb_rd_en;
  logic [7:0]  fb_data = 8'd0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, blank_n, frame_start;
  logic [9:0]  draw_x, draw_y;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .MAX_INTENSITY(100)
  ) dut (
    .clk(clk), .reset(reset), .calculating(calculating),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .frame_start(frame_start), .draw_x(draw_x), .draw_y(draw_y)
  );

  always #10 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          e_cnt = 0;
  int          rd_cnt = 0;
  int          bl_cnt = 0;
  int          nz_cnt = 0;
  int          mode = 1;
  logic [7:0]  const_val = 8'd0;
  logic        hold_m = 1'b0;
  logic [18:0] last_addr_m = 19'd0;
  out_t        cur_exp = RESET_OUT;
  out_t        sb[$];

  function automatic logic [7:0] mem_data(input logic [18:0] a);
    if (mode == 0) return const_val;
    return 8'((int'(a) * 13 + 5) % 256);
  endfunction

  // 1-clk read latency framebuffer
  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= mem_data(fb_addr);
  end

  function automatic logic [11:0] exp_rgb(input logic [7:0] d, input logic show);
    int i, lv;
    i  = (int'(d) > 100) ? 100 : int'(d);
    lv = (i * 157) >> 10;
    if (!show || i == 0) return 12'h000;
    return {4'(lv), 4'(lv >> 1), 4'(15 - lv)};
  endfunction

  function automatic logic is_act(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    e_cnt = 0; rd_cnt = 0; bl_cnt = 0;
    hold_m = 1'b0; last_addr_m = 19'd0;
    cur_exp = RESET_OUT;
    sb.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_blank_n", 32'(blank_n), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_draw_x", 32'(draw_x), 32'd0);
    chk("rst_draw_y", 32'(draw_y), 32'd0);
  endtask

  // One clk: advance, then compare every output against the model
  task automatic tick();
    int q, f, h, v, pd;
    logic exp_fs, exp_rd;
    out_t px;
    @(posedge clk); #1;
    e_cnt++;
    q = (e_cnt - 1) / 2;
    f = q % FR; h = f % HT; v = f / HT;
    exp_fs = 1'b0; exp_rd = 1'b0;
    if (e_cnt % 2 == 1) begin
      if (f == 0 && q >= FR) begin
        chk("reads_per_frame", 32'(rd_cnt), 32'(READS));
        chk("blank_clks_per_frame", 32'(bl_cnt), 32'(2 * READS));
        rd_cnt = 0; bl_cnt = 0;
      end
      exp_fs = (f == 0);
      exp_rd = is_act(h, v);
      if (exp_rd) last_addr_m = 19'(v * HA + h);
      if (e_cnt >= 3) begin
        chk("scoreboard_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) cur_exp = sb.pop_front();
      end else begin
        cur_exp = RESET_OUT;
      end
    end else begin
      if (f == 0) hold_m = calculating;
      px.rgb = exp_rgb(mem_data(19'(v * HA + h)), is_act(h, v) && !hold_m);
      px.hs  = !(h >= HA + HF && h < HA + HF + HS);
      px.vs  = !(v >= VA + VF && v < VA + VF + VS);
      px.bl  = is_act(h, v);
      sb.push_back(px);
    end
    pd = (e_cnt / 2) % FR;
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    chk("fb_rd_en", 32'(fb_rd_en), 32'(exp_rd));
    chk("fb_addr", 32'(fb_addr), 32'(last_addr_m));
    chk("draw_x", 32'(draw_x), 32'(pd % HT));
    chk("draw_y", 32'(draw_y), 32'(pd / HT));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(cur_exp.rgb));
    chk("hsync", 32'(hsync), 32'(cur_exp.hs));
    chk("vsync", 32'(vsync), 32'(cur_exp.vs));
    chk("blank_n", 32'(blank_n), 32'(cur_exp.bl));
    rd_cnt += int'(fb_rd_en);
    bl_cnt += int'(blank_n);
    if ({vga_r, vga_g, vga_b} != 12'h000) nz_cnt++;
  endtask

  // Run until the counters first show the given pixel of a frame
  task automatic run_to_pixel(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(((e_cnt / 2) % FR == target) && (e_cnt % 2 == 0)) && n < 4 * FR);
    chk("run_to_pixel_bound", 32'(n < 4 * FR), 32'd1);
  endtask

  // Constant memory contents; check the first visible pixel fetched after the change
  task automatic const_colour(input logic [7:0] val, input logic [11:0] want);
    logic found;
    mode = 0;
    const_val = val;
    repeat (6) tick();
    found = 1'b0;
    for (int i = 0; i < 2 * FR + 4; i++) begin
      tick();
      if (cur_exp.bl) begin
        found = 1'b1;
        break;
      end
    end
    chk("visible_found", 32'(found), 32'd1);
    chk("colour_const", 32'({vga_r, vga_g, vga_b}), 32'(want));
  endtask

  initial begin
    reset = 1'b1;
    calculating = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b0;
    reset_model();

    // Two full frames with a per-address ramp (timing, addresses, alignment, clamp)
    mode = 1;
    repeat (4 * FR) tick();

    // Directed colour map points
    const_colour(8'd100, 12'hF70);
    const_colour(8'd50,  12'h738);
    const_colour(8'd1,   12'h00F);
    const_colour(8'd0,   12'h000);
    const_colour(8'd200, 12'hF70);

    // Hold: busy at frame start, released mid-frame, next frame normal
    mode = 1;
    run_to_pixel(FR - 40);
    calculating = 1'b1;
    run_to_pixel(100);
    calculating = 1'b0;
    nz_cnt = 0;
    run_to_pixel(FR - 10);
    chk("held_frame_nonzero_clks", 32'(nz_cnt), 32'd0);
    nz_cnt = 0;
    run_to_pixel(FR - 10);
    chk("next_frame_has_colour", 32'(nz_cnt > 0), 32'd1);

    // Reset mid-frame inside the hsync pulse of a visible line
    run_to_pixel(4 * HT + 24);
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    repeat (5) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b0;
    reset_model();
    run_to_pixel(FR - 1);
    run_to_pixel(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
